// File: rtl/uart_tx_pkg.sv
// Shared constants for the UART transmit path: FSM state encoding and line levels.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Imported by uart_tx_fsm. The PARITY state is always part of the encoding.
// It is only reachable when the block is built with UART_TX_PARITY_EN.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  // Frame-bit levels on the serial line.
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic IDLE_LINE = 1'b1;

endpackage

// File: rtl/uart_tx_fsm_parity_calc.sv
// Parity flop: captures XOR of the offered byte (inverted for odd) when a frame is accepted.
// Latency: one clock from load to par_bit.
// Backpressure: none; load is a single-cycle strobe from the owning FSM.
//
// Ports:
//   CLK, RST (async active-low)  clock / reset; reset clears par_bit
//   P_DATA[DATA_WIDTH]           byte being accepted
//   PAR_TYP                      0 = even, 1 = odd
//   load                         capture strobe (frame acceptance)
//   par_bit                      registered parity bit, stable for the whole frame
module parity_calc #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  PAR_TYP,
  input  logic                  load,
  output logic                  par_bit
);

  // Held until the next acceptance. Later changes to P_DATA or PAR_TYP
  // cannot disturb a frame that is already on the line.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_bit <= 1'b0;
    end else if (load) begin
      par_bit <= (^P_DATA) ^ PAR_TYP;
    end
  end

endmodule

// File: rtl/uart_tx_fsm.sv
// UART transmit sequencer: frames an external serializer's bits as start/data/[parity]/stop.
// Latency: start bit on the line one clock after acceptance; 11-cycle (10 without parity) frame.
// Backpressure: busy high for the whole frame; Data_Valid is ignored until busy drops.
//
// Ports:
//   CLK, RST (async active-low)   clock / reset; reset returns the line to idle at once
//   P_DATA[DATA_WIDTH]            byte on offer, used only to compute parity
//   Data_Valid                    byte offer, accepted in IDLE
//   PAR_TYP                       0 = even, 1 = odd (unused without parity)
//   ser_done                      serializer is presenting its last data bit
//   ser_data                      serializer LSB, driven onto the line in DATA
//   ser_en                        serializer shift enable (DATA state only)
//   busy                          frame in progress; also blocks serializer reload
//   TX_OUT                        serial line, idle high
//
// Build option: define UART_TX_PARITY_EN to include the parity bit (11-bit frame).
// Without it the frame is 10 bits and PAR_TYP is ignored.
module uart_tx_fsm
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_TYP,
  input  logic                  ser_done,
  input  logic                  ser_data,
  output logic                  ser_en,
  output logic                  busy,
  output logic                  TX_OUT
);

  tx_state_e state_q, state_d;
  logic      accept;

  // Acceptance is the IDLE->START transition. It also loads the parity flop.
  assign accept = (state_q == IDLE) && Data_Valid;

`ifdef UART_TX_PARITY_EN
  logic par_bit;

  parity_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity_calc (
    .CLK     (CLK),
    .RST     (RST),
    .P_DATA  (P_DATA),
    .PAR_TYP (PAR_TYP),
    .load    (accept),
    .par_bit (par_bit)
  );
`else
  // Without parity the byte itself never reaches this block's logic.
  logic unused_par_inputs;
  assign unused_par_inputs = ^{P_DATA, PAR_TYP};
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs decode only the state register, the parity flop and the
  // serializer's LSB flop. No input reaches TX_OUT combinationally,
  // so the line cannot glitch on input changes.
  always_comb begin
    state_d = state_q;
    TX_OUT  = IDLE_LINE;
    ser_en  = 1'b0;
    busy    = 1'b1;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (accept) begin
          state_d = START;
        end
      end
      START: begin
        TX_OUT  = START_BIT;
        state_d = DATA;
      end
      DATA: begin
        TX_OUT = ser_data;
        ser_en = 1'b1;
        // No timeout: a stalled serializer keeps the frame in DATA.
        if (ser_done) begin
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
      PARITY: begin
`ifdef UART_TX_PARITY_EN
        TX_OUT  = par_bit;
`else
        TX_OUT  = STOP_BIT;
`endif
        state_d = STOP;
      end
      STOP: begin
        TX_OUT  = STOP_BIT;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fsm.sv
`timescale 1ns/1ps
module tb_uart_tx_fsm;
  localparam int DW = 8;
`ifdef UART_TX_PARITY_EN
  localparam int FL  = 11;
  localparam bit PAR = 1'b1;
`else
  localparam int FL  = 10;
  localparam bit PAR = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [DW-1:0] P_DATA = '0;
  logic          Data_Valid = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic          spur = 1'b0;
  logic          ser_done, ser_data, ser_en, busy, TX_OUT;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  always #5 CLK = ~CLK;

  uart_tx_fsm #(.DATA_WIDTH(DW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_TYP    (PAR_TYP),
    .ser_done   (ser_done),
    .ser_data   (ser_data),
    .ser_en     (ser_en),
    .busy       (busy),
    .TX_OUT     (TX_OUT)
  );

  // Simple external serializer: loads when the FSM accepts, shifts on ser_en.
  logic [DW-1:0] sr = '0;
  int            scnt = 0;
  assign ser_data = sr[0];
  assign ser_done = (scnt == DW - 1) || spur;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sr   <= '0;
      scnt <= 0;
    end else if (!busy && Data_Valid) begin
      sr   <= P_DATA;
      scnt <= 0;
    end else if (ser_en) begin
      sr   <= sr >> 1;
      scnt <= scnt + 1;
    end
  end

  // Reference model: one queue entry per line cycle of an accepted frame.
  typedef struct packed { logic tx; logic en; } slot_t;
  slot_t q[$];
  slot_t cur = '{tx: 1'b1, en: 1'b0};
  bit    cur_busy = 1'b0;

  function automatic slot_t mk(input logic tx, input logic en);
    slot_t s;
    s.tx = tx;
    s.en = en;
    return s;
  endfunction

  function automatic void push_frame(input logic [DW-1:0] d, input logic typ);
    q.push_back(mk(1'b0, 1'b0));
    for (int i = 0; i < DW; i++) q.push_back(mk(d[i], 1'b1));
    if (PAR) q.push_back(mk((^d) ^ typ, 1'b0));
    q.push_back(mk(1'b1, 1'b0));
  endfunction

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      q.delete();
      cur      = mk(1'b1, 1'b0);
      cur_busy = 1'b0;
    end else begin
      if (!cur_busy && Data_Valid) push_frame(P_DATA, PAR_TYP);
      if (q.size() > 0) begin
        cur      = q.pop_front();
        cur_busy = 1'b1;
      end else begin
        cur      = mk(1'b1, 1'b0);
        cur_busy = 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (cmp_on) begin
      chk("tx_vs_model",     {31'b0, TX_OUT}, {31'b0, cur.tx});
      chk("busy_vs_model",   {31'b0, busy},   {31'b0, cur_busy});
      chk("ser_en_vs_model", {31'b0, ser_en}, {31'b0, cur.en});
    end
  end

  // Caller sits in cycle 0 with Data_Valid already driven. Samples cycles 1..n
  // with cycle 1 landing in the MSB. Swaps P_DATA/PAR_TYP in cycle 1 and drops
  // Data_Valid in cycle drop_at.
  task automatic run_frame(input int n, input int drop_at, input logic [DW-1:0] nxt,
                           input logic nxt_typ, output logic [31:0] txv, output logic [31:0] bv);
    txv = '0;
    bv  = '0;
    for (int c = 1; c <= n; c++) begin
      @(negedge CLK);
      if (c == 1) begin
        P_DATA  = nxt;
        PAR_TYP = nxt_typ;
      end
      if (c == drop_at) Data_Valid = 1'b0;
      txv = {txv[30:0], TX_OUT};
      bv  = {bv[30:0], busy};
    end
  endtask

  logic [31:0] txv, bv, e_tx, e_b;

  initial begin
    #1 RST = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset_tx",     {31'b0, TX_OUT}, 32'd1);
    chk("reset_busy",   {31'b0, busy},   32'd0);
    chk("reset_ser_en", {31'b0, ser_en}, 32'd0);
    cmp_on = 1'b1;

    // 0xA5 even parity, offered during reset and accepted on the first edge after release.
    P_DATA = 8'hA5; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    #2 RST = 1'b1;
    run_frame(FL + 1, 1, 8'h3C, 1'b1, txv, bv);
`ifdef UART_TX_PARITY_EN
    e_tx = 32'b010100101011;     e_b = 32'b111111111110;
`else
    e_tx = 32'b01010010111;      e_b = 32'b11111111110;
`endif
    chk("a5_line", txv, e_tx);
    chk("a5_busy", bv, e_b);
    repeat (2) @(negedge CLK);

    // 0x01 odd then even; P_DATA/PAR_TYP scrambled after acceptance.
    for (int t = 0; t < 2; t++) begin
      P_DATA = 8'h01; PAR_TYP = (t == 0); Data_Valid = 1'b1;
      run_frame(FL + 1, 1, 8'($urandom), (t != 0), txv, bv);
      chk(t == 0 ? "par01_odd" : "par01_even", {31'b0, txv[FL + 1 - 10]},
          PAR ? ((t == 0) ? 32'd0 : 32'd1) : 32'd1);
      @(negedge CLK);
    end

    // Data_Valid held across two frames: 0x55 then 0xAA.
    P_DATA = 8'h55; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    run_frame(2 * FL + 1, FL + 2, 8'hAA, 1'b0, txv, bv);
`ifdef UART_TX_PARITY_EN
    e_tx = 32'b01010101001100101010101;
`else
    e_tx = 32'b010101010110010101011;
`endif
    chk("held_two_frames", txv, e_tx);
    repeat (2) @(negedge CLK);

    // 0xFF: eight ones, then busy falls right after the stop bit.
    P_DATA = 8'hFF; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    run_frame(FL + 1, 1, 8'h00, 1'b0, txv, bv);
`ifdef UART_TX_PARITY_EN
    e_tx = 32'b011111111011;     e_b = 32'b111111111110;
`else
    e_tx = 32'b01111111111;      e_b = 32'b11111111110;
`endif
    chk("ff_line", txv, e_tx);
    chk("ff_busy", bv, e_b);
    @(negedge CLK);

    // Reset asserted in cycle 5 of an all-zero frame.
    P_DATA = 8'h00; Data_Valid = 1'b1;
    run_frame(5, 1, 8'h00, 1'b0, txv, bv);
    chk("pre_reset_tx", {31'b0, TX_OUT}, 32'd0);
    #2 RST = 1'b0;
    #1;
    chk("midrst_tx",     {31'b0, TX_OUT}, 32'd1);
    chk("midrst_busy",   {31'b0, busy},   32'd0);
    chk("midrst_ser_en", {31'b0, ser_en}, 32'd0);
    repeat (2) @(negedge CLK);
    P_DATA = 8'hA5; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    #2 RST = 1'b1;
    run_frame(FL + 1, 1, 8'h00, 1'b1, txv, bv);
`ifdef UART_TX_PARITY_EN
    e_tx = 32'b010100101011;
`else
    e_tx = 32'b01010010111;
`endif
    chk("post_reset_a5", txv, e_tx);

    // Random traffic, with spurious ser_done outside DATA; checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      Data_Valid = ($urandom_range(0, 3) != 0);
      P_DATA     = 8'($urandom);
      PAR_TYP    = 1'($urandom);
      spur       = !cur.en && ($urandom_range(0, 3) == 0);
    end
    @(negedge CLK);
    spur = 1'b0;
    Data_Valid = 1'b0;
    repeat (FL + 2) @(negedge CLK);
    chk("final_idle_busy", {31'b0, busy}, 32'd0);
    cmp_on = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
